// File: rtl/ttl_scan_decoder.sv
// Multi-block scanning 1-of-N decoder: each block holds a loadable/incrementing
// address register and drives an active-low one-hot decode gated by Enable_bar.
module ttl_scan_decoder #(
  parameter int BLOCKS     = 2,
  parameter int WIDTH_IN   = 2,
  parameter int DELAY_RISE = 0,
  parameter int DELAY_FALL = 0
) (
  input  logic                               Clk,
  input  logic                               Clear_bar,
  input  logic [BLOCKS-1:0]                  Enable_bar,
  input  logic [BLOCKS-1:0]                  Load_bar,
  input  logic [BLOCKS-1:0]                  Count,
  input  logic [BLOCKS*WIDTH_IN-1:0]         A_2D,
  output logic [BLOCKS*(2**WIDTH_IN)-1:0]    Y_2D,
  output logic [BLOCKS*WIDTH_IN-1:0]         Q_2D,
  output logic [BLOCKS-1:0]                  TC
);

  localparam int WIDTH_OUT = 2 ** WIDTH_IN;

  logic [BLOCKS*WIDTH_IN-1:0]  addr;
  logic [BLOCKS*WIDTH_OUT-1:0] y;
  logic [BLOCKS-1:0]           tc;

  // Load beats Count; the increment wraps naturally at WIDTH_IN bits.
  always_ff @(posedge Clk or negedge Clear_bar) begin
    if (!Clear_bar) begin
      addr <= '0;
    end else begin
      for (int unsigned b = 0; b < BLOCKS; b++) begin
        if (!Load_bar[b]) begin
          addr[b*WIDTH_IN +: WIDTH_IN] <= A_2D[b*WIDTH_IN +: WIDTH_IN];
        end else if (Count[b]) begin
          addr[b*WIDTH_IN +: WIDTH_IN] <= addr[b*WIDTH_IN +: WIDTH_IN] + WIDTH_IN'(1);
        end
      end
    end
  end

  always_comb begin
    y  = '1;
    tc = '0;
    for (int unsigned b = 0; b < BLOCKS; b++) begin
      if (!Enable_bar[b]) begin
        y[b*WIDTH_OUT + int'(addr[b*WIDTH_IN +: WIDTH_IN])] = 1'b0;
      end
      tc[b] = Count[b] & (&addr[b*WIDTH_IN +: WIDTH_IN]);
    end
  end

  // Rise/fall delays have no hardware meaning; outputs are zero-delay and
  // negative delay settings are rejected by tying the outputs off.
  if (DELAY_RISE >= 0 && DELAY_FALL >= 0) begin : g_out
    assign Y_2D = y;
    assign Q_2D = addr;
    assign TC   = tc;
  end else begin : g_bad_delay
    assign Y_2D = '1;
    assign Q_2D = '0;
    assign TC   = '0;
  end

endmodule

// File: tb/tb_ttl_scan_decoder.sv
// Directed self-checking bench for ttl_scan_decoder (3 blocks of 2-to-4 decode).
module tb_ttl_scan_decoder;

  logic        Clk;
  logic        Clear_bar;
  logic [2:0]  Enable_bar;
  logic [2:0]  Load_bar;
  logic [2:0]  Count;
  logic [5:0]  A_2D;
  logic [11:0] Y_2D;
  logic [5:0]  Q_2D;
  logic [2:0]  TC;

  int passed = 0;
  int total  = 0;

  ttl_scan_decoder #(
    .BLOCKS(3),
    .WIDTH_IN(2),
    .DELAY_RISE(5),
    .DELAY_FALL(3)
  ) dut (
    .Clk(Clk),
    .Clear_bar(Clear_bar),
    .Enable_bar(Enable_bar),
    .Load_bar(Load_bar),
    .Count(Count),
    .A_2D(A_2D),
    .Y_2D(Y_2D),
    .Q_2D(Q_2D),
    .TC(TC)
  );

  task automatic edge_clk();
    Clk = 1'b1;
    #10;
    Clk = 1'b0;
    #10;
  endtask

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  initial begin
    Clk        = 1'b0;
    Clear_bar  = 1'b0;
    Enable_bar = 3'b000;
    Load_bar   = 3'b111;
    Count      = 3'b000;
    A_2D       = 6'b0;
    #10;
    check("reset_q",  12'(Q_2D), 12'b000000);
    check("reset_y",  Y_2D,      12'b1110_1110_1110);
    check("reset_tc", 12'(TC),   12'b000);

    Clear_bar = 1'b1;
    #10;
    Load_bar = 3'b000;
    A_2D     = {2'd3, 2'd1, 2'd2};
    edge_clk();
    check("load_q",  12'(Q_2D), 12'b11_01_10);
    check("load_y",  Y_2D,      12'b0111_1101_1011);
    check("load_tc", 12'(TC),   12'b000);

    Load_bar = 3'b111;
    Count    = 3'b001;
    A_2D     = 6'b0;
    #10;
    check("scan_pre_tc", 12'(TC), 12'b000);
    edge_clk();
    check("scan1_q",  12'(Q_2D), 12'b11_01_11);
    check("scan1_tc", 12'(TC),   12'b001);
    check("scan1_y",  Y_2D,      12'b0111_1101_0111);
    edge_clk();
    check("wrap_q",  12'(Q_2D), 12'b11_01_00);
    check("wrap_tc", 12'(TC),   12'b000);
    check("wrap_y",  Y_2D,      12'b0111_1101_1110);
    edge_clk();
    check("scan3_q", 12'(Q_2D), 12'b11_01_01);
    check("scan3_y", Y_2D,      12'b0111_1101_1101);

    Count = 3'b000;
    edge_clk();
    check("hold_q", 12'(Q_2D), 12'b11_01_01);

    Count      = 3'b010;
    Load_bar   = 3'b101;
    A_2D       = 6'b11_00_10;
    Enable_bar = 3'b010;
    #10;
    check("prio_pre_y", Y_2D, 12'b0111_1111_1101);
    edge_clk();
    check("prio_q", 12'(Q_2D), 12'b11_00_01);
    check("prio_y", Y_2D,      12'b0111_1111_1101);
    Enable_bar = 3'b000;
    #10;
    check("enable_y", Y_2D, 12'b0111_1110_1101);

    // TC ignores Enable_bar and Load_bar
    Load_bar   = 3'b011;
    Count      = 3'b100;
    Enable_bar = 3'b100;
    #10;
    check("tc_indep", 12'(TC), 12'b100);
    check("tc_indep_y", Y_2D, 12'b1111_1110_1101);

    Load_bar   = 3'b111;
    Enable_bar = 3'b000;
    Count      = 3'b111;
    #10;
    check("mid_pre_tc", 12'(TC), 12'b100);
    edge_clk();
    check("mid_q", 12'(Q_2D), 12'b00_01_10);
    Clear_bar = 1'b0;
    #10;
    check("async_q",  12'(Q_2D), 12'b000000);
    check("async_tc", 12'(TC),   12'b000);
    check("async_y",  Y_2D,      12'b1110_1110_1110);
    Clear_bar = 1'b1;
    #10;
    edge_clk();
    check("release_q", 12'(Q_2D), 12'b01_01_01);
    check("release_y", Y_2D,      12'b1101_1101_1101);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
